// File: rtl/calc_pkg.sv
// Shared calculator definitions: transmitter state encoding and default sizing.
package calc_pkg;

  localparam int CALC_WIDTH = 16;
  localparam int TX_DIV     = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } tx_state_t;

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-period timer: a down-counter that flags the last cycle of every DIV-cycle bit period.
module tx_bit_timer #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(DIV - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = RELOAD;
    end else if (en) begin
      cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // With DIV=1 the counter is pinned at zero, so tick follows en.
  assign tick = en && (cnt_q == '0);

endmodule

// File: rtl/serial_tx.sv
// Serial result transmitter: captures a result word and shifts it out MSB first.
// Define SERIAL_TX_PARITY_EN to append an even-parity bit after the LSB.
//
// state | meaning
// IDLE  | waiting for TxData; SampleData loads the holding register
// SHIFT | frame bits on DOut, each held DIV cycles, TxValid high
// DONE  | single cycle, TxDone pulse, then back to IDLE
module serial_tx
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH,
  parameter int DIV   = TX_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] DataIn,
  input  logic             SampleData,
  input  logic             TxData,
  output logic             DOut,
  output logic             TxValid,
  output logic             TxBusy,
  output logic             TxDone
);

`ifdef SERIAL_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FW = WIDTH + PAR;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(FW - 1);

  tx_state_t        state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [FW-1:0]    shift_q, shift_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             timer_clr, timer_en, tick;
  logic [WIDTH-1:0] load_word;
  logic [FW-1:0]    load_frame;

  // A same-cycle sample bypasses the holding register into the frame.
  assign load_word = SampleData ? DataIn : hold_q;

`ifdef SERIAL_TX_PARITY_EN
  assign load_frame = {load_word, ^load_word};
`else
  assign load_frame = load_word;
`endif

  tx_bit_timer #(.DIV(DIV)) u_bit_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (timer_clr),
    .en    (timer_en),
    .tick  (tick)
  );

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    timer_clr = 1'b0;
    timer_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (SampleData) hold_d = DataIn;
        if (TxData) begin
          state_d   = SHIFT;
          shift_d   = load_frame;
          bit_cnt_d = '0;
          timer_clr = 1'b1;
        end
      end
      SHIFT: begin
        timer_en = 1'b1;
        if (tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d = DONE;
          end else begin
            shift_d   = {shift_q[FW-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so they can be registered without added latency.
  always_comb begin
    dout_d  = (state_d == SHIFT) && shift_d[FW-1];
    valid_d = (state_d == SHIFT);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      dout_q    <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign DOut    = dout_q;
  assign TxValid = valid_q;
  assign TxBusy  = busy_q;
  assign TxDone  = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Randomized self-checking bench for serial_tx against a frame-level reference model.
module tb_serial_tx;

  localparam int WIDTH = 16;
  localparam int DIV   = 2;
`ifdef SERIAL_TX_PARITY_EN
  localparam int F = WIDTH + 1;
`else
  localparam int F = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] DataIn;
  logic             SampleData;
  logic             TxData;
  logic             DOut, TxValid, TxBusy, TxDone;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] m_hold;

  serial_tx #(.WIDTH(WIDTH), .DIV(DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .DataIn     (DataIn),
    .SampleData (SampleData),
    .TxData     (TxData),
    .DOut       (DOut),
    .TxValid    (TxValid),
    .TxBusy     (TxBusy),
    .TxDone     (TxDone)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Frame bit idx: word MSB first, then (optionally) the even-parity bit.
  function automatic logic frame_bit(input logic [WIDTH-1:0] w, input int idx);
    if (idx < WIDTH) return w[WIDTH-1-idx];
    return ^w;
  endfunction

  function automatic logic [3:0] outs();
    return {DOut, TxValid, TxBusy, TxDone};
  endfunction

  // Runs one transmission. Inputs change only on falling edges; checks are at falling edges.
  task automatic send_frame(input bit pre_sample, input bit simul, input logic [WIDTH-1:0] d,
                            input bit strobe_mid, input int strobe_j, input int abort_j);
    logic [WIDTH-1:0] word;
    if (pre_sample) begin
      @(negedge clk);
      SampleData = 1'b1;
      DataIn     = d;
      m_hold     = d;
      @(negedge clk);
      SampleData = 1'b0;
      chk("idle_after_sample", 32'(outs()), 32'h0);
    end else begin
      @(negedge clk);
    end
    TxData = 1'b1;
    if (simul) begin
      SampleData = 1'b1;
      DataIn     = d;
      m_hold     = d;
    end
    word = m_hold;
    for (int j = 0; j < F * DIV; j++) begin
      @(negedge clk);
      if (j == 0) begin
        TxData     = 1'b0;
        SampleData = 1'b0;
        DataIn     = WIDTH'($urandom);
      end
      if (j == abort_j) begin
        reset = 1'b0;
        #1 chk("abort_now", 32'(outs()), 32'h0);
        repeat (3) begin
          @(negedge clk);
          chk("abort_hold", 32'(outs()), 32'h0);
        end
        reset  = 1'b1;
        m_hold = '0;
        return;
      end
      chk("shift", 32'(outs()), 32'({frame_bit(word, j / DIV), 1'b1, 1'b1, 1'b0}));
      if (strobe_mid && j == strobe_j) begin
        TxData     = 1'b1;
        SampleData = 1'b1;
        DataIn     = '1;
      end
      if (strobe_mid && j == strobe_j + 1) begin
        TxData     = 1'b0;
        SampleData = 1'b0;
      end
    end
    @(negedge clk);
    chk("done", 32'(outs()), 32'b0011);
    @(negedge clk);
    chk("post_done", 32'(outs()), 32'h0);
  endtask

  initial begin
    reset      = 1'b0;
    DataIn     = '0;
    SampleData = 1'b0;
    TxData     = 1'b0;
    m_hold     = '0;
    #12 chk("reset_outs", 32'(outs()), 32'h0);
    #1 reset = 1'b1;

    // Transmission with nothing sampled sends zeros.
    send_frame(1'b0, 1'b0, '0, 1'b0, 0, -1);
    // Sample, then TxData one cycle later.
    send_frame(1'b1, 1'b0, 16'hA5C3, 1'b0, 0, -1);
    // Simultaneous strobes: new word bypasses into the frame.
    send_frame(1'b0, 1'b1, 16'h8001, 1'b0, 0, -1);
    // Mid-frame strobes ignored; next frame repeats the held word.
    send_frame(1'b0, 1'b0, '0, 1'b1, 7, -1);
    send_frame(1'b0, 1'b0, '0, 1'b0, 0, -1);
    chk("hold_kept", 32'(m_hold), 32'h8001);
    // Reset at bit 5 aborts the frame and clears the holding register.
    send_frame(1'b1, 1'b0, 16'h5A5A, 1'b0, 0, 5 * DIV);
    send_frame(1'b0, 1'b0, '0, 1'b0, 0, -1);
    // Parity-bit frame (odd ones count).
    send_frame(1'b1, 1'b0, 16'h0007, 1'b0, 0, -1);

    for (int k = 0; k < 20; k++) begin
      int mode;
      int gap;
      mode = $urandom_range(0, 2);
      send_frame(mode == 1, mode == 2, WIDTH'($urandom), 1'($urandom_range(0, 1)),
                 $urandom_range(0, F * DIV - 2), -1);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        SampleData = 1'b0;
        chk("gap_idle", 32'(outs()), 32'h0);
        if ($urandom_range(0, 1) == 1) begin
          SampleData = 1'b1;
          DataIn     = WIDTH'($urandom);
          m_hold     = DataIn;
        end
      end
      @(negedge clk);
      SampleData = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
